// File: rtl/sparse_idx_pkg.sv
// Shared types and default widths for the sorted-index intersection engine.
package sparse_idx_pkg;

  localparam int unsigned IDX_W_DEF = 4;
  localparam int unsigned TAG_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_LT = 2'b01,
    CMP_GT = 2'b10
  } cmp_code_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN_A = 3'd2,
    ST_DRAIN_B = 3'd3,
    ST_DONE    = 3'd4
  } isect_state_t;

  // Unsigned head compare; callers zero-extend indices up to 32 bits.
  function automatic cmp_code_t idx_cmp(input logic [31:0] a, input logic [31:0] b);
    if (a < b) return CMP_LT;
    if (a > b) return CMP_GT;
    return CMP_EQ;
  endfunction

endpackage

// File: rtl/sparse_idx_out_reg.sv
// Single-entry valid/ready holding register for match beats; accepts a new
// beat in the same cycle the held one is taken, so matches can stream at 1/cycle.
module sparse_idx_out_reg
  import sparse_idx_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [TAG_W-1:0] tag_a_i,
  input  logic [TAG_W-1:0] tag_b_i,
  input  logic             last_i,
  input  logic             m_ready_i,
  output logic             free_o,
  output logic             m_valid_o,
  output logic [IDX_W-1:0] m_idx_o,
  output logic [TAG_W-1:0] m_tag_a_o,
  output logic [TAG_W-1:0] m_tag_b_o,
  output logic             m_last_o
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_a_q, tag_a_d;
  logic [TAG_W-1:0] tag_b_q, tag_b_d;
  logic             last_q, last_d;

  assign free_o = !valid_q || m_ready_i;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    tag_a_d = tag_a_q;
    tag_b_d = tag_b_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      idx_d   = idx_i;
      tag_a_d = tag_a_i;
      tag_b_d = tag_b_i;
      last_d  = last_i;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
      idx_d   = '0;
      tag_a_d = '0;
      tag_b_d = '0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      tag_a_q <= '0;
      tag_b_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      tag_a_q <= tag_a_d;
      tag_b_q <= tag_b_d;
      last_q  <= last_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_idx_o   = idx_q;
  assign m_tag_a_o = tag_a_q;
  assign m_tag_b_o = tag_b_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/sparse_idx_intersect.sv
// Streaming merge of two ascending index streams, emitting tag pairs on equal heads.
// Optional ordering checker enabled by defining SPARSE_IDX_ORDER_CHECK_EN.
module sparse_idx_intersect
  import sparse_idx_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [TAG_W-1:0] a_tag,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [IDX_W-1:0] b_idx,
  input  logic [TAG_W-1:0] b_tag,
  input  logic             b_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [IDX_W-1:0] m_idx,
  output logic [TAG_W-1:0] m_tag_a,
  output logic [TAG_W-1:0] m_tag_b,
  output logic             m_last,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             err
);

  isect_state_t     state_q;
  logic             done_q;
  logic [CNT_W-1:0] match_cnt_q;
  cmp_code_t        cmp;
  logic             out_free;
  logic             load;
  logic             a_rdy, b_rdy;
  logic             a_take, b_take;

  assign cmp = idx_cmp(32'(a_idx), 32'(b_idx));

  // Readies are combinational on the current heads so a token is consumed
  // in the same cycle its comparison is decided.
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    load  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (a_valid && b_valid) begin
          case (cmp)
            CMP_LT:  a_rdy = 1'b1;
            CMP_GT:  b_rdy = 1'b1;
            default: begin
              if (out_free) begin
                a_rdy = 1'b1;
                b_rdy = 1'b1;
                load  = 1'b1;
              end
            end
          endcase
        end
      end
      ST_DRAIN_A: a_rdy = a_valid;
      ST_DRAIN_B: b_rdy = b_valid;
      default: ;
    endcase
  end

  assign a_take  = a_valid && a_rdy;
  assign b_take  = b_valid && b_rdy;
  assign a_ready = a_rdy;
  assign b_ready = b_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            match_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (load) begin
            if (match_cnt_q != '1) match_cnt_q <= match_cnt_q + CNT_W'(1);
            if (a_last && b_last) state_q <= ST_DONE;
            else if (a_last)      state_q <= ST_DRAIN_B;
            else if (b_last)      state_q <= ST_DRAIN_A;
          end else if (a_take && a_last) begin
            state_q <= ST_DRAIN_B;
          end else if (b_take && b_last) begin
            state_q <= ST_DRAIN_A;
          end
        end
        ST_DRAIN_A: if (a_take && a_last) state_q <= ST_DONE;
        ST_DRAIN_B: if (b_take && b_last) state_q <= ST_DONE;
        ST_DONE: begin
          // Completion is only signalled once the final match has left.
          if (!m_valid) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign match_cnt = match_cnt_q;

  sparse_idx_out_reg #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .idx_i     (a_idx),
    .tag_a_i   (a_tag),
    .tag_b_i   (b_tag),
    .last_i    (a_last | b_last),
    .m_ready_i (m_ready),
    .free_o    (out_free),
    .m_valid_o (m_valid),
    .m_idx_o   (m_idx),
    .m_tag_a_o (m_tag_a),
    .m_tag_b_o (m_tag_b),
    .m_last_o  (m_last)
  );

`ifdef SPARSE_IDX_ORDER_CHECK_EN
  logic [IDX_W-1:0] prev_a_q, prev_b_q;
  logic             seen_a_q, seen_b_q;
  logic             err_q;

  // A stream must be strictly ascending within a run; the first token of
  // each stream has nothing to compare against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_a_q <= '0;
      prev_b_q <= '0;
      seen_a_q <= 1'b0;
      seen_b_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      seen_a_q <= 1'b0;
      seen_b_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (a_take) begin
        if (seen_a_q && (a_idx <= prev_a_q)) err_q <= 1'b1;
        prev_a_q <= a_idx;
        seen_a_q <= 1'b1;
      end
      if (b_take) begin
        if (seen_b_q && (b_idx <= prev_b_q)) err_q <= 1'b1;
        prev_b_q <= b_idx;
        seen_b_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sparse_idx_intersect.sv
// Self-checking bench for sparse_idx_intersect: vector table, hand sequences, random runs vs model.
module tb_sparse_idx_intersect;

  localparam int IW = 4;
  localparam int TW = 8;
  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic          a_valid, a_ready, a_last, b_valid, b_ready, b_last;
  logic          m_valid, m_ready, m_last, done, err;
  logic [IW-1:0] a_idx, b_idx, m_idx;
  logic [TW-1:0] a_tag, b_tag, m_tag_a, m_tag_b;
  logic [CW-1:0] match_cnt;

  always #5 clk = ~clk;

  sparse_idx_intersect #(.IDX_W(IW), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_tag(a_tag), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_tag(b_tag), .b_last(b_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_tag_a(m_tag_a),
    .m_tag_b(m_tag_b), .m_last(m_last), .done(done), .match_cnt(match_cnt), .err(err)
  );

  int checks = 0;
  int failures = 0;

  logic [IW-1:0] sa_idx [16];
  logic [IW-1:0] sb_idx [16];
  logic [TW-1:0] sa_tag [16];
  logic [TW-1:0] sb_tag [16];
  int            na, nb;

  logic [IW-1:0] g_idx [$];
  logic [TW-1:0] g_ta [$];
  logic [TW-1:0] g_tb [$];
  logic          g_last [$];
  int            g_done_cyc, g_acc_cyc, g_ca, g_cb;
  logic          g_to, g_done2, g_err;
  logic [CW-1:0] g_cnt;

  typedef struct {
    int            na;
    int            nb;
    logic [IW-1:0] a [4];
    logic [IW-1:0] b [4];
    int            exp_n;
    logic [IW-1:0] exp_idx [4];
    logic          exp_last [4];
    int            exp_cnt;
    logic          exp_err;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Drive the loaded streams with optional valid gaps and m_ready stalls,
  // recording every accepted beat until done or a cycle budget runs out.
  task automatic run_stream(input int stall_pct, input int gap_pct);
    int cyc, ia, ib;
    g_idx.delete(); g_ta.delete(); g_tb.delete(); g_last.delete();
    g_done_cyc = -1; g_acc_cyc = -1; g_to = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; ia = 0; ib = 0;
    while (g_done_cyc < 0) begin
      if (cyc >= 400) begin
        g_to = 1'b1;
        break;
      end
      a_valid = (ia < na) && ($urandom_range(0, 99) >= gap_pct);
      a_idx   = sa_idx[ia % 16];
      a_tag   = sa_tag[ia % 16];
      a_last  = (ia == na - 1);
      b_valid = (ib < nb) && ($urandom_range(0, 99) >= gap_pct);
      b_idx   = sb_idx[ib % 16];
      b_tag   = sb_tag[ib % 16];
      b_last  = (ib == nb - 1);
      m_ready = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      if (a_valid && a_ready) ia++;
      if (b_valid && b_ready) ib++;
      if (m_valid && m_ready) begin
        g_idx.push_back(m_idx); g_ta.push_back(m_tag_a);
        g_tb.push_back(m_tag_b); g_last.push_back(m_last);
        g_acc_cyc = cyc;
      end
      if (done) g_done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b0;
    g_ca = ia; g_cb = ib;
    @(negedge clk);
    g_done2 = done;
    g_cnt = match_cnt;
    g_err = err;
  endtask

  task automatic chk_run(input string nm, input int exp_n, input int exp_cnt, input logic exp_err);
    chk({nm, "_timeout"}, 32'(g_to), 32'd0);
    chk({nm, "_consumed_a"}, g_ca, na);
    chk({nm, "_consumed_b"}, g_cb, nb);
    chk({nm, "_nbeats"}, g_idx.size(), exp_n);
    chk({nm, "_match_cnt"}, 32'(g_cnt), exp_cnt);
    chk({nm, "_err"}, 32'(g_err), 32'(exp_err));
    chk({nm, "_done_width"}, 32'(g_done2), 32'd0);
    if (exp_n > 0) chk({nm, "_done_after_last_beat"}, 32'(g_done_cyc > g_acc_cyc), 32'd1);
  endtask

  // Reference: intersection of the two index lists, in A order, with the
  // tags of the matching positions; m_last when either side was its final token.
  task automatic model_check(input string nm);
    logic [IW-1:0] e_idx [$];
    logic [TW-1:0] e_ta [$];
    logic [TW-1:0] e_tb [$];
    logic          e_last [$];
    int n;
    for (int i = 0; i < na; i++)
      for (int j = 0; j < nb; j++)
        if (sa_idx[i] == sb_idx[j]) begin
          e_idx.push_back(sa_idx[i]); e_ta.push_back(sa_tag[i]);
          e_tb.push_back(sb_tag[j]); e_last.push_back((i == na - 1) || (j == nb - 1));
        end
    n = e_idx.size();
    chk_run(nm, n, (n > CNT_MAX) ? CNT_MAX : n, 1'b0);
    for (int k = 0; k < n && k < g_idx.size(); k++) begin
      chk($sformatf("%s_idx%0d", nm, k), 32'(g_idx[k]), 32'(e_idx[k]));
      chk($sformatf("%s_taga%0d", nm, k), 32'(g_ta[k]), 32'(e_ta[k]));
      chk($sformatf("%s_tagb%0d", nm, k), 32'(g_tb[k]), 32'(e_tb[k]));
      chk($sformatf("%s_last%0d", nm, k), 32'(g_last[k]), 32'(e_last[k]));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic exp_order_err;
`ifdef SPARSE_IDX_ORDER_CHECK_EN
    exp_order_err = 1'b1;
`else
    exp_order_err = 1'b0;
`endif
    vt[0].na = 4; vt[0].nb = 4;
    vt[0].a = '{4'd1, 4'd3, 4'd5, 4'd9}; vt[0].b = '{4'd3, 4'd4, 4'd9, 4'd12};
    vt[0].exp_n = 2; vt[0].exp_idx = '{4'd3, 4'd9, 4'd0, 4'd0};
    vt[0].exp_last = '{1'b0, 1'b1, 1'b0, 1'b0}; vt[0].exp_cnt = 2; vt[0].exp_err = 1'b0;
    vt[1].na = 2; vt[1].nb = 2;
    vt[1].a = '{4'd0, 4'd2, 4'd0, 4'd0}; vt[1].b = '{4'd1, 4'd3, 4'd0, 4'd0};
    vt[1].exp_n = 0; vt[1].exp_idx = '{4'd0, 4'd0, 4'd0, 4'd0};
    vt[1].exp_last = '{1'b0, 1'b0, 1'b0, 1'b0}; vt[1].exp_cnt = 0; vt[1].exp_err = 1'b0;
    vt[2].na = 1; vt[2].nb = 1;
    vt[2].a = '{4'hF, 4'd0, 4'd0, 4'd0}; vt[2].b = '{4'hF, 4'd0, 4'd0, 4'd0};
    vt[2].exp_n = 1; vt[2].exp_idx = '{4'hF, 4'd0, 4'd0, 4'd0};
    vt[2].exp_last = '{1'b1, 1'b0, 1'b0, 1'b0}; vt[2].exp_cnt = 1; vt[2].exp_err = 1'b0;
    vt[3].na = 3; vt[3].nb = 1;
    vt[3].a = '{4'd5, 4'd3, 4'd8, 4'd0}; vt[3].b = '{4'd8, 4'd0, 4'd0, 4'd0};
    vt[3].exp_n = 1; vt[3].exp_idx = '{4'd8, 4'd0, 4'd0, 4'd0};
    vt[3].exp_last = '{1'b1, 1'b0, 1'b0, 1'b0}; vt[3].exp_cnt = 1; vt[3].exp_err = exp_order_err;

    rst_n = 1'b0; start = 1'b0; m_ready = 1'b1;
    a_valid = 1'b1; a_idx = 4'd3; a_tag = 8'h11; a_last = 1'b0;
    b_valid = 1'b1; b_idx = 4'd3; b_tag = 8'h22; b_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'({a_ready, b_ready, m_valid, m_last, done, err}), 32'd0);
    chk("rst_m_idx", 32'(m_idx), 32'd0);
    chk("rst_m_tags", 32'({m_tag_a, m_tag_b}), 32'd0);
    chk("rst_match_cnt", 32'(match_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_readies", 32'({a_ready, b_ready, m_valid}), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;

    for (int t = 0; t < 4; t++) begin
      na = vt[t].na; nb = vt[t].nb;
      for (int i = 0; i < 4; i++) begin
        sa_idx[i] = vt[t].a[i]; sa_tag[i] = {4'hA, vt[t].a[i]};
        sb_idx[i] = vt[t].b[i]; sb_tag[i] = {4'hB, vt[t].b[i]};
      end
      run_stream(0, 0);
      chk_run($sformatf("tbl%0d", t), vt[t].exp_n, vt[t].exp_cnt, vt[t].exp_err);
      if (vt[t].exp_n > 0)
        chk($sformatf("tbl%0d_done_latency", t), 32'(g_done_cyc - g_acc_cyc <= 2), 32'd1);
      for (int k = 0; k < vt[t].exp_n && k < g_idx.size(); k++) begin
        chk($sformatf("tbl%0d_idx%0d", t, k), 32'(g_idx[k]), 32'(vt[t].exp_idx[k]));
        chk($sformatf("tbl%0d_taga%0d", t, k), 32'(g_ta[k]), 32'({4'hA, vt[t].exp_idx[k]}));
        chk($sformatf("tbl%0d_tagb%0d", t, k), 32'(g_tb[k]), 32'({4'hB, vt[t].exp_idx[k]}));
        chk($sformatf("tbl%0d_last%0d", t, k), 32'(g_last[k]), 32'(vt[t].exp_last[k]));
      end
    end

    // Backpressure: second match must wait while the first is held.
    m_ready = 1'b0;
    a_valid = 1'b1; a_idx = 4'd6; a_tag = 8'hA6; a_last = 1'b0;
    b_valid = 1'b1; b_idx = 4'd6; b_tag = 8'hB6; b_last = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("bp_first_consume", 32'({a_ready, b_ready}), 32'd3);
    @(posedge clk); #1;
    a_idx = 4'd7; a_tag = 8'hA7; a_last = 1'b1;
    b_idx = 4'd7; b_tag = 8'hB7; b_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), 32'({m_valid, m_idx, m_tag_a, m_tag_b, a_ready, b_ready}),
          32'({1'b1, 4'd6, 8'hA6, 8'hB6, 2'b00}));
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'({m_valid, m_idx, a_ready, b_ready}), 32'({1'b1, 4'd6, 2'b11}));
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_beat", 32'({m_valid, m_idx, m_tag_a, m_tag_b, m_last}),
        32'({1'b1, 4'd7, 8'hA7, 8'hB7, 1'b1}));
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("bp_done", 32'(seen), 32'd1);
    chk("bp_match_cnt", 32'(match_cnt), 32'd2);
    m_ready = 1'b0;

    // Reset in the middle of a run with one match pending.
    @(posedge clk); #1;
    m_ready = 1'b0;
    a_valid = 1'b1; a_idx = 4'd2; a_tag = 8'h12; a_last = 1'b0;
    b_valid = 1'b1; b_idx = 4'd2; b_tag = 8'h22; b_last = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a_idx = 4'd5; b_idx = 4'd7;
    @(negedge clk);
    chk("mr_pending", 32'({m_valid, m_idx, match_cnt}), 32'({1'b1, 4'd2, 3'd1}));
    #1 rst_n = 1'b0;
    #1;
    chk("mr_async_ctrl", 32'({a_ready, b_ready, m_valid, m_last, done, err}), 32'd0);
    chk("mr_async_data", 32'({m_idx, m_tag_a, m_tag_b, match_cnt}), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("mr_no_done", 32'(seen), 32'd0);
    chk("mr_idle", 32'({a_ready, b_ready, m_valid}), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;

    for (int r = 0; r < 40; r++) begin
      na = 0; nb = 0;
      for (int v = 0; v < 16; v++) begin
        if ($urandom_range(0, 99) < 50) begin
          sa_idx[na] = IW'(v); sa_tag[na] = TW'($urandom); na++;
        end
        if ($urandom_range(0, 99) < 50) begin
          sb_idx[nb] = IW'(v); sb_tag[nb] = TW'($urandom); nb++;
        end
      end
      if (na == 0) begin sa_idx[0] = IW'($urandom_range(0, 15)); sa_tag[0] = 8'h5A; na = 1; end
      if (nb == 0) begin sb_idx[0] = IW'($urandom_range(0, 15)); sb_tag[0] = 8'hA5; nb = 1; end
      run_stream($urandom_range(0, 60), $urandom_range(0, 40));
      model_check($sformatf("rnd%0d", r));
    end

    // Every index on both sides: 16 matches, counter pinned at its maximum.
    na = 16; nb = 16;
    for (int v = 0; v < 16; v++) begin
      sa_idx[v] = IW'(v); sa_tag[v] = TW'($urandom);
      sb_idx[v] = IW'(v); sb_tag[v] = TW'($urandom);
    end
    run_stream(30, 10);
    model_check("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
